// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit PRBS generator/checker pair:
// the Galois next-state function, checker FSM states and default seed.
package lfsr_pkg;

  localparam logic [7:0] LFSR_SEED = 8'hFF;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  // One Galois step; the (low bits == 0) term splices 0x00 into the cycle
  // so every 8-bit value is a sequence member.
  function automatic logic [7:0] lfsr8_next(input logic [7:0] cur);
    logic fb;
    fb = cur[7] ^ (cur[6:0] == 7'd0);
    return {cur[6], cur[5] ^ fb, cur[4] ^ fb, cur[3],
            cur[2], cur[1], cur[0] ^ fb, fb};
  endfunction

endpackage

// File: rtl/lfsr_sat_counter.sv
// Saturating statistics counter: adds a variable amount when enabled,
// clamps at all-ones instead of wrapping, clear has priority.
module lfsr_sat_counter #(
  parameter int W     = 16,
  parameter int INC_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc_en,
  input  logic [INC_W-1:0] inc_amt,
  output logic [W-1:0]     count
);

  // One spare bit above the wider operand so the overflow is visible.
  localparam int SUM_W = ((W > INC_W) ? W : INC_W) + 1;
  localparam logic [SUM_W-1:0] SUM_MAX = {{(SUM_W-W){1'b0}}, {W{1'b1}}};

  logic [W-1:0]     count_q;
  logic [W-1:0]     count_d;
  logic [SUM_W-1:0] sum_s;

  // Next count: clear, clamped add, or hold.
  always_comb begin
    sum_s   = SUM_W'(count_q) + SUM_W'(inc_amt);
    count_d = count_q;
    if (clr) begin
      count_d = {W{1'b0}};
    end else if (inc_en) begin
      if (sum_s > SUM_MAX) begin
        count_d = {W{1'b1}};
      end else begin
        count_d = sum_s[W-1:0];
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/lfsr_checker.sv
// PRBS receive end: self-synchronises to an 8-bit LFSR word stream,
// free-runs its prediction once locked and reports/counts mismatches.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [7:0]       i_data,
  input  logic             i_clear,
  output logic             o_lock,
  output logic             o_err,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [CNT_W-1:0] o_bit_err_cnt,
  output logic [CNT_W-1:0] o_word_cnt
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int UW = $clog2(UNLOCK_CNT + 1);

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  chk_state_e    state_q, state_d;
  logic [7:0]    expected_q, expected_d;
  logic [MW-1:0] match_q, match_d;
  logic [UW-1:0] miss_q, miss_d;
  logic          lock_q, lock_d;
  logic          err_q, err_d;

  logic          hit_s;
  logic [3:0]    diff_bits_s;
  logic          ev_err_s;
  logic          ev_word_s;

  // FSM next state, prediction update and per-word error events.
  always_comb begin
    hit_s       = (i_data == expected_q);
    diff_bits_s = popcount8(i_data ^ expected_q);
    state_d     = state_q;
    expected_d  = expected_q;
    match_d     = match_q;
    miss_d      = miss_q;
    err_d       = 1'b0;
    ev_err_s    = 1'b0;
    ev_word_s   = 1'b0;
    if (i_valid) begin
      case (state_q)
        HUNT: begin
          expected_d = lfsr8_next(i_data);
          match_d    = {MW{1'b0}};
          state_d    = VERIFY;
        end
        VERIFY: begin
          // Until locked, always follow the received word.
          expected_d = lfsr8_next(i_data);
          if (hit_s) begin
            match_d = match_q + MW'(1);
            if (match_q == MW'(LOCK_CNT - 1)) begin
              state_d = LOCKED;
              miss_d  = {UW{1'b0}};
            end else begin
              state_d = VERIFY;
            end
          end else begin
            match_d = {MW{1'b0}};
          end
        end
        LOCKED: begin
          // Free-run so a corrupted word never re-seeds the prediction.
          expected_d = lfsr8_next(expected_q);
          ev_word_s  = 1'b1;
          if (hit_s) begin
            miss_d = {UW{1'b0}};
          end else begin
            err_d    = 1'b1;
            ev_err_s = 1'b1;
            miss_d   = miss_q + UW'(1);
            if (miss_q == UW'(UNLOCK_CNT - 1)) begin
              state_d = HUNT;
            end else begin
              state_d = LOCKED;
            end
          end
        end
        default: begin
          state_d    = HUNT;
          expected_d = 8'h00;
          match_d    = {MW{1'b0}};
          miss_d     = {UW{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end
    lock_d = (state_d == LOCKED);
  end

  // State, prediction and output registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_q    <= HUNT;
      expected_q <= 8'h00;
      match_q    <= {MW{1'b0}};
      miss_q     <= {UW{1'b0}};
      lock_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      match_q    <= match_d;
      miss_q     <= miss_d;
      lock_q     <= lock_d;
      err_q      <= err_d;
    end
  end

  lfsr_sat_counter #(.W(CNT_W), .INC_W(4)) u_err_cnt (
    .clk     (clk),
    .rst_n   (i_rst_n),
    .clr     (i_clear),
    .inc_en  (ev_err_s),
    .inc_amt (4'd1),
    .count   (o_err_cnt)
  );

  lfsr_sat_counter #(.W(CNT_W), .INC_W(4)) u_bit_err_cnt (
    .clk     (clk),
    .rst_n   (i_rst_n),
    .clr     (i_clear),
    .inc_en  (ev_err_s),
    .inc_amt (diff_bits_s),
    .count   (o_bit_err_cnt)
  );

  lfsr_sat_counter #(.W(CNT_W), .INC_W(4)) u_word_cnt (
    .clk     (clk),
    .rst_n   (i_rst_n),
    .clr     (i_clear),
    .inc_en  (ev_word_s),
    .inc_amt (4'd1),
    .count   (o_word_cnt)
  );

  assign o_lock = lock_q;
  assign o_err  = err_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: lock/unlock, error pulses and counts,
// valid gaps, saturation (narrow-counter instance), clear and reset.
module tb_lfsr_checker;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [7:0]  data;
  logic        clr;

  logic        lock, err;
  logic [15:0] err_cnt, bit_cnt, word_cnt;
  logic        lock_s, err_s;
  logic [3:0]  err_cnt_s, bit_cnt_s, word_cnt_s;

  int          total_cnt;
  int          bad_cnt;
  logic [7:0]  gen;

  lfsr_checker dut (
    .clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data), .i_clear(clr),
    .o_lock(lock), .o_err(err), .o_err_cnt(err_cnt),
    .o_bit_err_cnt(bit_cnt), .o_word_cnt(word_cnt)
  );

  lfsr_checker #(.CNT_W(4)) dut_s (
    .clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data), .i_clear(clr),
    .o_lock(lock_s), .o_err(err_s), .o_err_cnt(err_cnt_s),
    .o_bit_err_cnt(bit_cnt_s), .o_word_cnt(word_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] tb_next(input logic [7:0] l);
    logic fb;
    fb = l[7] ^ (l[6:0] == 7'd0);
    return {l[6], l[5] ^ fb, l[4] ^ fb, l[3], l[2], l[1], l[0] ^ fb, fb};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge: apply inputs, let one rising edge consume them,
  // return at the next falling edge where outputs are stable.
  task automatic cyc(input logic v, input logic [7:0] d, input logic c);
    valid = v;
    data  = d;
    clr   = c;
    @(negedge clk);
    valid = 1'b0;
    clr   = 1'b0;
  endtask

  task automatic send_good();
    cyc(1'b1, gen, 1'b0);
    gen = tb_next(gen);
  endtask

  task automatic send_bad(input logic [7:0] mask);
    cyc(1'b1, gen ^ mask, 1'b0);
    gen = tb_next(gen);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    int nv;
    total_cnt = 0;
    bad_cnt   = 0;
    rst_n = 1'b0; valid = 1'b0; data = 8'h00; clr = 1'b0;
    @(negedge clk);

    // 1: reset state, lock after the 5th good word, word count from the 6th
    do_reset();
    check("rst_lock", {31'd0, lock}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_errcnt", {16'd0, err_cnt}, 32'd0);
    check("rst_bitcnt", {16'd0, bit_cnt}, 32'd0);
    check("rst_wordcnt", {16'd0, word_cnt}, 32'd0);
    gen = 8'hFF;
    check("seq_w2", {24'd0, tb_next(gen)}, 32'h9D);
    for (int k = 1; k <= 5; k++) begin
      send_good();
      check("t1_lock", {31'd0, lock}, (k == 5) ? 32'd1 : 32'd0);
    end
    check("t1_wordcnt0", {16'd0, word_cnt}, 32'd0);
    check("t1_errcnt0", {16'd0, err_cnt}, 32'd0);
    send_good();
    check("t1_wordcnt1", {16'd0, word_cnt}, 32'd1);

    // 2: single corrupted word
    send_bad(8'h05);
    check("t2_err", {31'd0, err}, 32'd1);
    check("t2_errcnt", {16'd0, err_cnt}, 32'd1);
    check("t2_bitcnt", {16'd0, bit_cnt}, 32'd2);
    check("t2_lock", {31'd0, lock}, 32'd1);
    check("t2_wordcnt", {16'd0, word_cnt}, 32'd2);
    send_good();
    check("t2_err_gone", {31'd0, err}, 32'd0);
    send_good();
    check("t2_err_gone2", {31'd0, err}, 32'd0);
    check("t2_errcnt_hold", {16'd0, err_cnt}, 32'd1);
    check("t2_wordcnt4", {16'd0, word_cnt}, 32'd4);

    // 3: clear, three consecutive errors drop lock, then relock
    cyc(1'b0, 8'h00, 1'b1);
    check("t3_clr_err", {16'd0, err_cnt}, 32'd0);
    check("t3_clr_word", {16'd0, word_cnt}, 32'd0);
    check("t3_clr_lock", {31'd0, lock}, 32'd1);
    for (int k = 1; k <= 3; k++) begin
      send_bad(8'h05);
      check("t3_err", {31'd0, err}, 32'd1);
      check("t3_lock", {31'd0, lock}, (k == 3) ? 32'd0 : 32'd1);
    end
    check("t3_errcnt", {16'd0, err_cnt}, 32'd3);
    check("t3_bitcnt", {16'd0, bit_cnt}, 32'd6);
    for (int k = 1; k <= 5; k++) begin
      send_good();
      check("t3_relock", {31'd0, lock}, (k == 5) ? 32'd1 : 32'd0);
      check("t3_noerr", {31'd0, err}, 32'd0);
    end

    // 4: random valid gaps, stream 0x01.. passes 0x00 while locked
    do_reset();
    gen = 8'h01;
    nv  = 0;
    for (int c = 0; c < 200 && nv < 12; c++) begin
      if ($urandom_range(0, 1) == 1) begin
        send_good();
        nv++;
      end else begin
        cyc(1'b0, 8'($urandom_range(0, 255)), 1'b0);
      end
      check("t4_lock", {31'd0, lock}, (nv >= 5) ? 32'd1 : 32'd0);
      check("t4_err", {31'd0, err}, 32'd0);
    end
    check("t4_budget", nv, 32'd12);
    check("t4_errcnt", {16'd0, err_cnt}, 32'd0);
    check("t4_wordcnt", {16'd0, word_cnt}, 32'd7);

    // 5: saturation on the 4-bit instance, clear wins over a same-cycle error
    do_reset();
    gen = 8'hFF;
    for (int k = 0; k < 5; k++) send_good();
    for (int k = 1; k <= 20; k++) begin
      send_bad(8'h01);
      check("t5_err_s", {31'd0, err_s}, 32'd1);
      check("t5_errcnt_s", {28'd0, err_cnt_s}, (k > 15) ? 32'd15 : k);
      send_good();
    end
    check("t5_bitcnt_s", {28'd0, bit_cnt_s}, 32'd15);
    check("t5_wordcnt_s", {28'd0, word_cnt_s}, 32'd15);
    check("t5_lock_s", {31'd0, lock_s}, 32'd1);
    check("t5_errcnt", {16'd0, err_cnt}, 32'd20);
    check("t5_wordcnt", {16'd0, word_cnt}, 32'd40);
    cyc(1'b1, gen ^ 8'h10, 1'b1);
    gen = tb_next(gen);
    check("t5_clr_err_s", {31'd0, err_s}, 32'd1);
    check("t5_clr_errcnt_s", {28'd0, err_cnt_s}, 32'd0);
    check("t5_clr_bitcnt_s", {28'd0, bit_cnt_s}, 32'd0);
    check("t5_clr_wordcnt_s", {28'd0, word_cnt_s}, 32'd0);
    check("t5_clr_errcnt", {16'd0, err_cnt}, 32'd0);
    check("t5_clr_lock", {31'd0, lock}, 32'd1);

    // 6: reset while LOCKED and while VERIFY, then lock mid-sequence
    send_bad(8'h03);
    check("t6_pre_errcnt", {16'd0, err_cnt}, 32'd1);
    rst_n = 1'b0;
    cyc(1'b1, gen ^ 8'h0F, 1'b1);
    rst_n = 1'b1;
    check("t6_lk_lock", {31'd0, lock}, 32'd0);
    check("t6_lk_err", {31'd0, err}, 32'd0);
    check("t6_lk_errcnt", {16'd0, err_cnt}, 32'd0);
    check("t6_lk_bitcnt", {16'd0, bit_cnt}, 32'd0);
    check("t6_lk_wordcnt", {16'd0, word_cnt}, 32'd0);
    gen = 8'hFF;
    for (int k = 0; k < 3; k++) send_good();
    rst_n = 1'b0;
    cyc(1'b1, gen, 1'b0);
    rst_n = 1'b1;
    check("t6_vf_lock", {31'd0, lock}, 32'd0);
    check("t6_vf_err", {31'd0, err}, 32'd0);
    gen = 8'h59;
    for (int k = 1; k <= 5; k++) begin
      send_good();
      check("t6_relock", {31'd0, lock}, (k == 5) ? 32'd1 : 32'd0);
    end
    send_good();
    check("t6_wordcnt", {16'd0, word_cnt}, 32'd1);
    check("t6_errcnt", {16'd0, err_cnt}, 32'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
